// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of up to eight common-anode digits
// through one shared 3-bit segment decoder. A small host-written register
// file holds {vis, value} per digit; the FSM alternates a dead-time BLANK
// gap with a SHOW dwell for each digit in turn.
module seg_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [3:0]        wr_data,
    output logic              dec_en,
    output logic [2:0]        dec_in,
    output logic [DIGITS-1:0] digit_sel,
    output logic [2:0]        cur_digit,
    output logic              frame_done
);

    // The dwell counter only needs to reach the larger of the two phase lengths.
    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cur_q, cur_d;
    logic             frame_q, frame_d;

    logic [3:0]       rf_q [DIGITS];
    logic [3:0]       cur_ent;
    logic             show_vis;

    // Register file: one write per cycle, addresses beyond the last digit
    // match no entry and are therefore dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (wr_addr == 3'(i)) begin
                    rf_q[i] <= wr_data;
                end
            end
        end
    end

    // Read port for the digit being scanned; combinational so a write to the
    // lit digit appears in the very next cycle.
    always_comb begin
        cur_ent = 4'b0000;
        for (int i = 0; i < DIGITS; i++) begin
            if (cur_q == 3'(i)) begin
                cur_ent = rf_q[i];
            end
        end
    end

    // State register together with the dwell counter, digit index and frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cur_q   <= 3'd0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            frame_q <= frame_d;
        end
    end

    // Next-state logic; dropping run returns to IDLE ahead of any other move.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        frame_d = 1'b0;
        if (!run) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cur_d   = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    cur_d   = 3'd0;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        if (cur_q == LAST_DIGIT) begin
                            cur_d   = 3'd0;
                            frame_d = 1'b1;
                        end else begin
                            cur_d = cur_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    cur_d   = 3'd0;
                end
            endcase
        end
    end

    // Output decode: only SHOW lights anything, and only a visible digit.
    always_comb begin
        show_vis   = (state_q == ST_SHOW) && cur_ent[3];
        dec_en     = show_vis;
        dec_in     = (state_q == ST_SHOW) ? cur_ent[2:0] : 3'd0;
        cur_digit  = cur_q;
        frame_done = frame_q;
    end

    // Active-low select: at most the current digit's line, and only with dec_en.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_sel
            assign digit_sel[gi] = ~(show_vis && (cur_q == 3'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
// Stimulus pushes the expected per-cycle outputs into a queue; a monitor on
// the falling edge pops and compares them against the DUT.
module tb_seg_scan_ctrl;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int DIG_PER   = BLANK_CYC + SCAN_DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              wr_en = 1'b0;
    logic [2:0]        wr_addr = 3'd0;
    logic [3:0]        wr_data = 4'd0;
    logic              dec_en;
    logic [2:0]        dec_in;
    logic [DIGITS-1:0] digit_sel;
    logic [2:0]        cur_digit;
    logic              frame_done;

    seg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dec_en    (dec_en),
        .dec_in    (dec_in),
        .digit_sel (digit_sel),
        .cur_digit (cur_digit),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sel;
        logic       en;
        logic [2:0] din;
        logic       fd;
        logic [2:0] cur;
        string      name;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] ent [DIGITS];   // bench's own record of what was written

    task automatic push(input logic [3:0] sel, input logic en, input logic [2:0] din,
                        input logic fd, input logic [2:0] cur, input string name);
        exp_t e;
        e.sel  = sel;
        e.en   = en;
        e.din  = din;
        e.fd   = fd;
        e.cur  = cur;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Let one rising edge happen, then record what the outputs must be after it.
    task automatic cyc(input logic [3:0] sel, input logic en, input logic [2:0] din,
                       input logic fd, input logic [2:0] cur, input string name);
        @(posedge clk);
        #1;
        push(sel, en, din, fd, cur, name);
    endtask

    task automatic dark(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            cyc(4'hF, 1'b0, 3'd0, 1'b0, 3'd0, name);
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        $display("write addr=%0d data=%b (idle)", a, d);
        if (a < DIGITS) ent[a] = d;
        cyc(4'hF, 1'b0, 3'd0, 1'b0, 3'd0, "idle_write");
        wr_en = 1'b0;
    endtask

    // One digit period: BLANK cycles then SHOW cycles. Optionally a host
    // write lands at edge wr_cyc, or run drops before edge stop_cyc.
    task automatic scan_digit(input int d, input bit fd_first, input int wr_cyc,
                              input logic [2:0] wa, input logic [3:0] wd, input int stop_cyc);
        logic [3:0] sel;
        logic [3:0] e;
        for (int i = 0; i < DIG_PER; i++) begin
            if (i == stop_cyc) begin
                run   = 1'b0;
                wr_en = 1'b0;
                $display("run dropped during digit %0d cycle %0d", d, i);
                cyc(4'hF, 1'b0, 3'd0, 1'b0, 3'd0, "stop_dark");
                return;
            end
            if (i == wr_cyc) begin
                wr_en   = 1'b1;
                wr_addr = wa;
                wr_data = wd;
                $display("write addr=%0d data=%b (digit %0d cycle %0d)", wa, wd, d, i);
                if (wa < DIGITS) ent[wa] = wd;
            end else begin
                wr_en = 1'b0;
            end
            if (i < BLANK_CYC) begin
                cyc(4'hF, 1'b0, 3'd0, (i == 0) && fd_first, 3'(d),
                    $sformatf("d%0d_blank%0d", d, i));
            end else begin
                e   = ent[d];
                sel = e[3] ? ~(4'b0001 << d) : 4'hF;
                cyc(sel, e[3], e[2:0], 1'b0, 3'(d), $sformatf("d%0d_show%0d", d, i - BLANK_CYC));
            end
        end
        wr_en = 1'b0;
    endtask

    // Monitor: compare each expected cycle and the select/enable invariant.
    initial begin
        exp_t e;
        int   lows;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({digit_sel, dec_en, dec_in, frame_done, cur_digit} !==
                    {e.sel, e.en, e.din, e.fd, e.cur}) begin
                    bad++;
                    $display("FAIL %s: got sel=%b en=%b in=%0d fd=%b cur=%0d, want sel=%b en=%b in=%0d fd=%b cur=%0d",
                             e.name, digit_sel, dec_en, dec_in, frame_done, cur_digit,
                             e.sel, e.en, e.din, e.fd, e.cur);
                end
                lows = $countones(~digit_sel);
                total++;
                if (!((lows == 0) || ((lows == 1) && (dec_en === 1'b1)))) begin
                    bad++;
                    $display("FAIL %s_invariant: got sel=%b en=%b, want at most one low bit and only with en=1",
                             e.name, digit_sel, dec_en);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DIGITS; i++) ent[i] = 4'b0000;

        // Reset held, then released with run low.
        $display("phase: reset and idle");
        dark(2, "in_reset");
        rst = 1'b0;
        dark(20, "idle");

        // Load the register file and start scanning.
        $display("phase: basic scan");
        host_write(3'd0, 4'b1101);
        host_write(3'd1, 4'b1001);
        host_write(3'd2, 4'b1111);
        host_write(3'd3, 4'b1010);
        run = 1'b1;
        for (int d = 0; d < DIGITS; d++) scan_digit(d, 1'b0, -1, 3'd0, 4'd0, -1);

        // Frame 2: digit 2 made invisible; frame_done opens the frame.
        $display("phase: invisible digit");
        scan_digit(0, 1'b1, 0, 3'd2, 4'b0110, -1);
        for (int d = 1; d < DIGITS; d++) scan_digit(d, 1'b0, -1, 3'd0, 4'd0, -1);

        // Frame 3: write the lit digit, out-of-range write, then stop mid-SHOW.
        $display("phase: write during show, out-of-range write, stop");
        scan_digit(0, 1'b1, -1, 3'd0, 4'd0, -1);
        scan_digit(1, 1'b0, 5, 3'd1, 4'b1100, -1);
        scan_digit(2, 1'b0, 3, 3'd6, 4'b1011, -1);
        scan_digit(3, 1'b0, -1, 3'd0, 4'd0, 5);
        dark(3, "stopped");

        // Restart: full BLANK, digit 0 first, no frame_done pulse.
        $display("phase: restart");
        run = 1'b1;
        scan_digit(0, 1'b0, -1, 3'd0, 4'd0, -1);
        cyc(4'hF, 1'b0, 3'd0, 1'b0, 3'd1, "d1_blank0");
        cyc(4'hF, 1'b0, 3'd0, 1'b0, 3'd1, "d1_blank1");
        cyc(4'b1101, 1'b1, 3'd4, 1'b0, 3'd1, "d1_show0");
        cyc(4'b1101, 1'b1, 3'd4, 1'b0, 3'd1, "d1_show1");

        // Asynchronous reset between edges while digit 1 is lit.
        $display("phase: async reset mid-frame");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        push(4'hF, 1'b0, 3'd0, 1'b0, 3'd0, "async_rst");
        for (int i = 0; i < DIGITS; i++) ent[i] = 4'b0000;
        dark(2, "rst_held");
        rst = 1'b0;
        for (int d = 0; d < DIGITS; d++) scan_digit(d, 1'b0, -1, 3'd0, 4'd0, -1);
        scan_digit(0, 1'b1, -1, 3'd0, 4'd0, -1);
        run = 1'b0;
        dark(2, "final_idle");

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Multiplexed scan controller that time-shares a single 3-bit-to-segment decoder among up to eight common-anode digits. It holds a small per-digit register file written by the host. It steps through the digits with a programmable dwell and a dead-time gap against ghosting. It drives the decoder's `en`/`in` inputs and the active-low digit-select lines. It sits between host/control logic and the segment decoder on the display board.

## Interface

Parameters:
- `DIGITS`, default 8: number of scanned digits, legal range 2..8.
- `SCAN_DIV`, default 1000: clock cycles each digit is lit (SHOW dwell), legal range ≥ 2.
- `BLANK_CYC`, default 4: dead-time cycles before each digit with all digits off, legal range ≥ 1.

Ports:
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `run`, in, 1: scan enable, level-sensitive.
- `wr_en`, in, 1: host write strobe, one write per cycle.
- `wr_addr`, in, 3: digit index to write.
- `wr_data`, in, 4: `{vis, value[2:0]}`; `vis`=1 makes the digit visible.
- `dec_en`, out, 1: decoder enable.
- `dec_in`, out, 3: decoder value input.
- `digit_sel`, out, DIGITS: active-low one-hot digit select.
- `cur_digit`, out, 3: index of the digit currently being scanned.
- `frame_done`, out, 1: one-cycle pulse per completed scan frame.

## Operation

- Register file holds DIGITS entries of 4 bits.
  - `wr_en`=1 writes `wr_data` to entry `wr_addr` at the clock edge.
  - Writes with `wr_addr` ≥ DIGITS are ignored.
  - Writes are accepted in every FSM state, including IDLE.
- FSM states are IDLE, BLANK and SHOW. The dwell counter width is clog2(max(SCAN_DIV, BLANK_CYC)).
  - IDLE → BLANK when `run`=1. Clear the counter and set `cur_digit`=0.
  - BLANK → SHOW after BLANK_CYC cycles in BLANK. Clear the counter.
  - SHOW → BLANK after SCAN_DIV cycles in SHOW.
    - If `cur_digit`=DIGITS-1, `cur_digit` wraps to 0 and `frame_done` pulses.
    - Otherwise `cur_digit` increments.
  - Any state → IDLE at the next edge when `run`=0; this has priority over every other transition. Counter and `cur_digit` are cleared.
- Output rules, all outputs derived from registered state plus the register file:
  - In SHOW: `dec_en` = entry[cur_digit].vis and `dec_in` = entry[cur_digit].value.
  - In SHOW: `digit_sel` has bit `cur_digit` low when `vis`=1; otherwise all ones.
  - In IDLE and BLANK: `dec_en`=0, `dec_in`=0, `digit_sel` all ones.
  - Invariant: a `digit_sel` bit is low only while `dec_en`=1, and never more than one bit is low.
- A write to the digit currently in SHOW shows on `dec_in`/`digit_sel` in the cycle after the write edge, with no glitch to other digits.
- Simultaneous write and wrap: the write lands in the register file; the scan sequence is unaffected.

## Timing

- Reset values:
  - State IDLE, counter 0, `cur_digit`=0, every register-file entry 4'b0000.
  - `dec_en`=0, `dec_in`=0, `digit_sel` all ones, `frame_done`=0.
- Reset asserted mid-scan forces these values immediately and asynchronously, without waiting for a clock edge.
- After `run` is sampled high at edge k:
  - BLANK is active during cycles k..k+BLANK_CYC-1.
  - SHOW starts at edge k+BLANK_CYC.
- Digit period is BLANK_CYC+SCAN_DIV cycles; frame period is DIGITS×(BLANK_CYC+SCAN_DIV).
- `frame_done` is high for exactly one cycle: the first BLANK cycle of digit 0 after the wrap. It is never asserted on the initial IDLE→BLANK entry.
- `run` sampled low at edge m: outputs are dark from edge m onward (IDLE). A later `run`=1 restarts at digit 0 with a full BLANK.

## Test plan

Use DIGITS=4, SCAN_DIV=8, BLANK_CYC=2 (digit period 10, frame 40).

1. **Reset and idle.** Hold `rst`=1, then release with `run`=0 for 20 cycles. Expect `digit_sel`=4'b1111, `dec_en`=0, `frame_done`=0 throughout.
2. **Basic scan.** Write entries 0..3 = `{1,3'd5}`, `{1,3'd1}`, `{1,3'd7}`, `{1,3'd2}`, then set `run`=1.
   - Expect 2 dark cycles, then `digit_sel`=4'b1110 with `dec_in`=5 for 8 cycles.
   - Then 2 dark cycles, then 4'b1101 with `dec_in`=1, and so on through digits 2 and 3.
   - Expect a `frame_done` pulse at cycle 40 after start.
3. **Invisible digit.** Write entry 2 = `{0,3'd6}`. During digit 2's SHOW, expect `digit_sel`=4'b1111 and `dec_en`=0. Timing is unchanged and the next `frame_done` still comes 40 cycles later.
4. **Write during SHOW and out-of-range write.**
   - During digit 1's SHOW, write entry 1 = `{1,3'd4}`. Expect `dec_in`=4 from the next cycle, with `digit_sel` constant.
   - Write `wr_addr`=6. Expect no change to any entry.
5. **Stop/restart.** Drop `run` during digit 3's SHOW.
   - Expect all-ones `digit_sel` next cycle and `cur_digit`=0.
   - Reassert `run`: expect a 2-cycle BLANK, then digit 0, and no `frame_done` pulse on restart.
6. **Async reset mid-frame.** Assert `rst` between clock edges during SHOW. Expect outputs dark immediately, and all entries read back as invisible after release (display stays dark with `run`=1).
